// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default sizes for the sequence match checker
package seq_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, HOLD} seq_state_t;
  localparam int SEQ_WIDTH_DEF = 8;
  localparam int SEQ_HOLD_DEF = 80;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: two-flop synchroniser plus rising-edge detect, one-cycle GO per press
module btn_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic GO
);
  logic [2:0] sr;
  always_ff @(posedge CLK or posedge RST)
    if (RST) sr <= '0;
    else sr <= {sr[1:0], BTN};
  assign GO = sr[1] & ~sr[2];
endmodule

// File: rtl/seq_match_checker.sv
// seq_match_checker: bit-serial target/guess compare with mismatch tolerance and win streak
// SEQ_RESULT_HOLD_EN: hold WIN/LOSE for HOLD_CYCLES clocks in a HOLD state instead of pulsing
module seq_match_checker
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEF,
  parameter int MAX_ERR = 0,
  parameter int HOLD_CYCLES = SEQ_HOLD_DEF,
  parameter int STREAK_W = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BTN,
  input  logic [WIDTH-1:0]             LEDS,
  input  logic [WIDTH-1:0]             SW,
  output logic                         BUSY,
  output logic                         WIN,
  output logic                         LOSE,
  output logic [$clog2(WIDTH+1)-1:0]   ERR_CNT,
  output logic [$clog2(WIDTH)-1:0]     FIRST_BAD,
  output logic                         BAD_VALID,
  output logic [STREAK_W-1:0]          STREAK
);
  localparam int EW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [EW-1:0] MAXE = EW'(MAX_ERR);
  localparam logic [STREAK_W-1:0] SMAX = '1;
  if (WIDTH < 2 || MAX_ERR < 0 || MAX_ERR >= WIDTH || HOLD_CYCLES < 1) begin : g_bad_cfg
    $error("seq_match_checker: parameter out of range");
  end
  seq_state_t state, state_nxt;
  logic go, mis, win_now, lose_now, win_nxt, lose_nxt;
  logic [WIDTH-1:0] tgt, gss;
  logic [IW-1:0] idx;
  logic [EW-1:0] err_inc;
  btn_edge_sync u_sync (.CLK(CLK), .RST(RST), .BTN(BTN), .GO(go));
`ifdef SEQ_RESULT_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold_cnt;
  logic hold_done;
  assign hold_done = hold_cnt == HW'(HOLD_CYCLES - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) hold_cnt <= '0;
    else hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : '0;
`endif
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    mis = gss[idx] ^ tgt[idx];
    err_inc = ERR_CNT + EW'(mis);
    lose_now = state == CHECK && err_inc > MAXE;
    win_now = state == CHECK && !lose_now && idx == LAST;
`ifdef SEQ_RESULT_HOLD_EN
    state_nxt = state == IDLE ? (go ? CHECK : IDLE)
              : state == CHECK ? (win_now || lose_now ? HOLD : CHECK)
              : (hold_done ? IDLE : HOLD);
    win_nxt = win_now || (WIN && state == HOLD && !hold_done);
    lose_nxt = lose_now || (LOSE && state == HOLD && !hold_done);
`else
    state_nxt = state == IDLE ? (go ? CHECK : IDLE) : (win_now || lose_now ? IDLE : CHECK);
    win_nxt = win_now;
    lose_nxt = lose_now;
`endif
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tgt <= '0;
      gss <= '0;
      idx <= '0;
      ERR_CNT <= '0;
      FIRST_BAD <= '0;
      BAD_VALID <= 1'b0;
      WIN <= 1'b0;
      LOSE <= 1'b0;
      STREAK <= '0;
    end else begin
      WIN <= win_nxt;
      LOSE <= lose_nxt;
      if (state == IDLE && go) begin
        tgt <= LEDS;
        gss <= SW;
        idx <= '0;
        ERR_CNT <= '0;
        BAD_VALID <= 1'b0;
      end
      if (state == CHECK) begin
        idx <= idx + 1'b1;
        if (mis) begin
          ERR_CNT <= err_inc;
          if (!BAD_VALID) begin
            FIRST_BAD <= idx;
            BAD_VALID <= 1'b1;
          end
        end
      end
      if (win_now) STREAK <= STREAK == SMAX ? STREAK : STREAK + 1'b1;
      if (lose_now) STREAK <= '0;
    end
endmodule

// File: tb/tb_seq_match_checker.sv
// tb_seq_match_checker: randomized rounds scored against a bit-loop reference model
module tb_seq_match_checker;
  localparam int W = 8, MAXE = 1, HOLD = 10, SWID = 2;
  localparam int EW = $clog2(W + 1), IW = $clog2(W);
  localparam int SMAX = (1 << SWID) - 1;
`ifdef SEQ_RESULT_HOLD_EN
  localparam int RES_W = HOLD;
  localparam int RES_BUSY = 1;
`else
  localparam int RES_W = 1;
  localparam int RES_BUSY = 0;
`endif
  typedef struct {
    logic win;
    int   err;
    int   fb;
    logic bv;
    int   streak;
    int   due;
  } exp_t;
  logic CLK = 0, RST = 1, BTN = 0;
  logic [W-1:0] LEDS = '0, SW = '0;
  logic BUSY, WIN, LOSE, BAD_VALID;
  logic [EW-1:0] ERR_CNT;
  logic [IW-1:0] FIRST_BAD;
  logic [SWID-1:0] STREAK;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0, cyc = 0, streak_m = 0, width = 0;
  logic res_d = 0;
  seq_match_checker #(.WIDTH(W), .MAX_ERR(MAXE), .HOLD_CYCLES(HOLD), .STREAK_W(SWID)) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .LEDS(LEDS), .SW(SW), .BUSY(BUSY), .WIN(WIN), .LOSE(LOSE),
    .ERR_CNT(ERR_CNT), .FIRST_BAD(FIRST_BAD), .BAD_VALID(BAD_VALID), .STREAK(STREAK)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: walk bits LSB first, stop at the mismatch that exceeds the tolerance.
  task automatic launch(input logic [W-1:0] t, input logic [W-1:0] g);
    exp_t e;
    int n = 0, j = W - 1;
    e.fb = 0;
    e.bv = 0;
    for (int i = 0; i < W; i++) begin
      if (t[i] != g[i]) begin
        if (!e.bv) begin e.fb = i; e.bv = 1; end
        n++;
        if (n > MAXE) begin j = i; break; end
      end
    end
    e.err = n;
    e.win = n <= MAXE;
    streak_m = e.win ? (streak_m < SMAX ? streak_m + 1 : streak_m) : 0;
    e.streak = streak_m;
    e.due = cyc + 4 + j;
    q.push_back(e);
    LEDS = t;
    SW = g;
    BTN = 1;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || BUSY) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", int'(n >= 400), 0);
    if (n >= 400) q.delete();
    repeat (3) @(negedge CLK);
  endtask
  task automatic round(input logic [W-1:0] t, input logic [W-1:0] g, input bit interfere, input int hold_len);
    launch(t, g);
    @(negedge CLK);
    if (interfere) begin
      BTN = 0;
      @(negedge CLK);
      BTN = 1;
    end
    repeat (2) @(negedge CLK);
    LEDS = W'($urandom);
    SW = W'($urandom);
    repeat (hold_len) @(negedge CLK);
    BTN = 0;
    drain();
  endtask
  always @(negedge CLK) begin
    if (RST) begin
      res_d = 0;
      width = 0;
    end else begin
      if (WIN && LOSE) chk("win_lose_exclusive", 1, 0);
      if ((WIN || LOSE) && !res_d) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          me = q.pop_front();
          chk("win", int'(WIN), int'(me.win));
          chk("lose", int'(LOSE), int'(!me.win));
          chk("err_cnt", int'(ERR_CNT), me.err);
          chk("bad_valid", int'(BAD_VALID), int'(me.bv));
          if (me.bv) chk("first_bad", int'(FIRST_BAD), me.fb);
          chk("streak", int'(STREAK), me.streak);
          chk("latency_cycle", cyc, me.due);
          chk("busy_at_result", int'(BUSY), RES_BUSY);
        end
      end
      if (!(WIN || LOSE) && res_d) chk("result_width", width, RES_W);
      width = (WIN || LOSE) ? width + 1 : 0;
      res_d = WIN || LOSE;
    end
  end
  initial begin
    logic [W-1:0] t, g;
    int c;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_win", int'(WIN), 0);
    chk("rst_lose", int'(LOSE), 0);
    chk("rst_err_cnt", int'(ERR_CNT), 0);
    chk("rst_first_bad", int'(FIRST_BAD), 0);
    chk("rst_bad_valid", int'(BAD_VALID), 0);
    chk("rst_streak", int'(STREAK), 0);
    RST = 0;
    repeat (3) @(negedge CLK);
    round(8'hA5, 8'hA5, 0, 1);
    round(8'hA5, 8'hA4, 0, 1);
    round(8'hF0, 8'h70, 0, 2);
    round(8'hF0, 8'h30, 0, 1);
    round(8'hA5, 8'h5A, 1, 3);
    round(8'h3C, 8'h3C, 1, 100);
    for (int r = 0; r < 40; r++) begin
      t = W'($urandom);
      g = t;
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) g[$urandom_range(0, W - 1)] ^= 1'b1;
      round(t, g, 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
    end
`ifndef SEQ_RESULT_HOLD_EN
    launch(8'h81, 8'h81);
    @(negedge CLK);
    BTN = 0;
    repeat (W) @(negedge CLK);
    launch(8'h0F, 8'h0C);
    @(negedge CLK);
    BTN = 0;
    drain();
`endif
    for (int r = 0; r < 5; r++) round(8'h66, 8'h66, 0, 1);
    launch(8'h00, 8'h00);
    c = cyc;
    @(negedge CLK);
    BTN = 0;
    repeat (6) @(negedge CLK);
    chk("pre_reset_cycle", cyc, c + 7);
    RST = 1;
    #1;
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_win", int'(WIN), 0);
    chk("mid_rst_err_cnt", int'(ERR_CNT), 0);
    chk("mid_rst_streak", int'(STREAK), 0);
    q.delete();
    streak_m = 0;
    @(negedge CLK);
    RST = 0;
    repeat (2) @(negedge CLK);
    round(8'hC3, 8'hC3, 0, 1);
    round(8'hC3, 8'h3C, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
